// File: rtl/h80_bus_mem_mp.sv
// Multi-channel word/byte memory behind a round-robin arbiter; one access in flight.
// Requests and completions are signalled with run/done toggles.
module h80_bus_mem_mp #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 32768,
    parameter int NCH       = 2,
    parameter int WAIT      = 0,
    parameter     INIT_FILE = ""
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NCH-1:0][ADDR_W-1:0]    addr,
    input  logic [NCH-1:0][2:0]           cmd,
    input  logic [NCH-1:0]                run,
    input  logic [NCH-1:0][DATA_W-1:0]    wr_data,
    output logic [NCH-1:0][DATA_W-1:0]    rd_data,
    output logic [NCH-1:0]                done,
    output logic [NCH-1:0]                err
);
    localparam int NB     = DATA_W / 8;
    localparam int LB     = (NB > 1) ? $clog2(NB) : 1;
    localparam int IDX_W  = ADDR_W - LB;
    localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        CMD_READ_W  = 3'd0,
        CMD_WRITE_W = 3'd1,
        CMD_READ_B  = 3'd2,
        CMD_WRITE_B = 3'd3
    } bus_cmd_t;

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [CH_W-1:0]            last_q, ch_q;
    logic [IDX_W-1:0]           idx_q;
    logic [LB-1:0]              lane_q;
    logic [2:0]                 cmd_q;
    logic [DATA_W-1:0]          wdata_q;
    logic                       bad_q;
    logic [NCH-1:0]             done_q, err_q;
    logic [NCH-1:0][DATA_W-1:0] rd_q;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;

    logic [NCH-1:0]    pending;
    logic              gnt_valid;
    logic [CH_W-1:0]   gnt_ch, cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [IDX_W-1:0]  sel_idx;
    logic [2:0]        sel_cmd;
    logic              sel_bad;
    logic              start, finish, mem_we;
    logic [DATA_W-1:0] mem_wdata, rd_byte;

    assign pending  = run ^ done_q;
    assign sel_addr = addr[gnt_ch];
    assign sel_cmd  = cmd[gnt_ch];
    assign sel_idx  = sel_addr[ADDR_W-1:LB];
    assign sel_bad  = (64'(sel_idx) >= 64'(DEPTH)) || (sel_cmd > CMD_WRITE_B);

    // Round-robin: first pending channel after the last one granted.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = CH_W'((int'(last_q) + 1 + k) % NCH);
            if (!gnt_valid && pending[cand]) begin
                gnt_valid = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    start   = 1'b1;
                    cnt_d   = 4'(WAIT);
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    finish  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Byte writes merge into the word fetched at grant time.
    always_comb begin
        mem_wdata = mem_rd_q;
        if (cmd_q == CMD_WRITE_W) begin
            mem_wdata = wdata_q;
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (lane_q == LB'(b)) mem_wdata[b*8 +: 8] = wdata_q[7:0];
            end
        end
    end

    always_comb begin
        rd_byte = '0;
        for (int b = 0; b < NB; b++) begin
            if (lane_q == LB'(b)) rd_byte[7:0] = mem_rd_q[b*8 +: 8];
        end
    end

    assign mem_we = finish && !bad_q && (cmd_q == CMD_WRITE_W || cmd_q == CMD_WRITE_B);

    always_ff @(posedge clk) begin
        if (start)  mem_rd_q <= mem[MEM_AW'(sel_idx)];
        if (mem_we) mem[MEM_AW'(idx_q)] <= mem_wdata;
    end

    initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= CH_W'(NCH - 1);
            ch_q    <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            cmd_q   <= '0;
            wdata_q <= '0;
            bad_q   <= 1'b0;
            done_q  <= '0;
            err_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (start) begin
                last_q  <= gnt_ch;
                ch_q    <= gnt_ch;
                idx_q   <= sel_idx;
                lane_q  <= sel_addr[LB-1:0];
                cmd_q   <= sel_cmd;
                wdata_q <= wr_data[gnt_ch];
                bad_q   <= sel_bad;
            end
            if (finish) begin
                done_q[ch_q] <= ~done_q[ch_q];
                err_q[ch_q]  <= bad_q;
                if (cmd_q == CMD_READ_W)
                    rd_q[ch_q] <= bad_q ? '0 : mem_rd_q;
                else if (cmd_q == CMD_READ_B)
                    rd_q[ch_q] <= bad_q ? '0 : rd_byte;
            end
        end
    end

    assign rd_data = rd_q;
    assign done    = done_q;
    assign err     = err_q;
endmodule
